ysyx_23060203_lsu: RTL
======================

Name: ysyx_23060203_lsu

Overview:
Parametrised load/store unit that replaces the combinational, DPI-backed memory stage with a handshaked, multi-cycle access path. It accepts one load or store per transaction from the execute stage and issues a word-aligned request with a byte strobe to a generic memory port. It tolerates arbitrary memory latency and back-pressure, realigns and sign/zero-extends load data, and flags misaligned or illegal accesses instead of issuing them. It sits between EXU and WBU; one transaction is in flight at a time.

Parameters:
XLEN, 32, data width in bits; 32 or 64 only.
AW, 32, address width in bits.
SB, XLEN/8, derived byte count per beat; not overridable.
OB, log2(SB), derived offset width (2 for XLEN=32, 3 for XLEN=64).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  request valid from EXU
in_ready  out  1  LSU can accept a request
in_wen  in  1  1=store, 0=load
in_func  in  3  [1:0] size: 0=B, 1=H, 2=W, 3=D. [2]: load unsigned; must be 0 for stores.
in_addr  in  AW  byte address
in_wdata  in  XLEN  store data, LSB-justified
out_valid  out  1  response valid to WBU (issued for loads and stores)
out_ready  in  1  WBU accepts response
out_rdata  out  XLEN  extended load data; 0 for stores and errors
out_err  out  1  misaligned or illegal access
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_wen  out  1  write request
mem_addr  out  AW  in_addr with low OB bits cleared
mem_wdata  out  XLEN  store data shifted to its byte lane
mem_wstrb  out  SB  byte strobe; 0 for reads
mem_rvalid  in  1  read data / write acknowledge valid (always accepted)
mem_rdata  in  XLEN  raw aligned read word

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE. in_ready=1; out_valid=0; mem_valid=0; out_rdata=0; out_err=0; mem_wen=0; mem_addr=0; mem_wdata=0; mem_wstrb=0. All request/response registers cleared.
- FSM states: IDLE, REQ, WAIT, RESP. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready, latch wen, func, addr and wdata, then classify:
  - illegal: size=3 with XLEN=32, or func[2]=1 with wen=1.
  - misaligned: addr mod (1<<size) != 0.
  - If illegal or misaligned, go to RESP with out_err=1 and out_rdata=0. mem_valid is never asserted.
  - Otherwise go to REQ.
- REQ: mem_valid=1. mem_* outputs are registered and held stable until mem_valid&mem_ready. Then go to WAIT.
- Strobe and store data: off = addr[OB-1:0]. mem_wstrb = ((1<<(1<<size))-1) << off for stores, 0 for loads. mem_wdata = in_wdata << (8*off); bits outside the strobe are don't-care and must be driven as the shifted value.
- WAIT: on mem_rvalid, go to RESP.
  - Load: shifted = mem_rdata >> (8*off). Keep the low (8<<size) bits, then sign-extend (func[2]=0) or zero-extend (func[2]=1) to XLEN.
  - Store: out_rdata=0.
  - out_err=0 in both cases.
- RESP: out_valid=1. out_rdata and out_err are held until out_valid&out_ready, then go to IDLE.
- Latency with no back-pressure: request accepted at cycle T; mem_valid at T+1; mem_rvalid earliest T+2; out_valid T+3. Error path: out_valid at T+1.
- mem_rvalid outside WAIT is ignored. A mem_rvalid coinciding with the mem handshake cycle is illegal from the memory side; the LSU ignores it.
- Synchronous reset in any state aborts the transaction with no response. A late mem_rvalid after reset is ignored (state IDLE).
- The registered datapath allows no combinational path from in_* to out_* or mem_*.

Test Plan:
1. XLEN=32, LB at 0x80000001, mem_rdata=0x123480FF -> mem_addr=0x80000000, mem_wstrb=0000, out_rdata=0xFFFFFF80, out_err=0. Same access as LBU -> 0x00000080. LHU at 0x80000002 -> 0x00001234.
2. SH at 0x80000002, in_wdata=0x0000ABCD -> mem_wen=1, mem_addr=0x80000000, mem_wstrb=1100, mem_wdata=0xABCD0000. After mem_rvalid: out_valid=1, out_rdata=0, out_err=0.
3. Errors:
   - LW at 0x80000002 -> no mem_valid, out_valid at T+1, out_err=1, out_rdata=0.
   - func=011 with XLEN=32 -> out_err=1.
   - Store with func[2]=1 -> out_err=1.
4. Back-pressure: mem_ready low for 3 cycles, mem_rvalid 4 cycles after the mem handshake, out_ready low for 2 cycles -> mem_* and out_* stable while stalled, in_ready=0 throughout, exactly one mem handshake and one out handshake.
5. Reset asserted in WAIT -> next cycle all outputs at reset values, in_ready=1. A following mem_rvalid causes no out_valid.
6. XLEN=64, LW at 0x...04, mem_rdata=0x87654321_00000000 -> out_rdata=0xFFFFFFFF87654321. SD at an aligned address -> mem_wstrb=0xFF.

Source files
------------

// File: rtl/ysyx_23060203_lsu.sv
// ysyx_23060203_lsu: handshaked multi-cycle load/store unit between EXU and WBU.
// One transaction in flight; misaligned/illegal accesses answer with out_err_o and never reach memory.
module ysyx_23060203_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    localparam int SB  = XLEN / 8,
    localparam int OB  = $clog2(SB)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_wen_i,
    input  logic [2:0]      in_func_i,
    input  logic [AW-1:0]   in_addr_i,
    input  logic [XLEN-1:0] in_wdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_rdata_o,
    output logic            out_err_o,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic            mem_wen_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [SB-1:0]   mem_wstrb_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_q;
    logic            wen_q;
    logic [2:0]      func_q;
    logic [OB-1:0]   off_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [SB-1:0]   wstrb_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [1:0]      size;
    logic [OB-1:0]   off_d;
    logic [7:0]      bmask;
    logic [2:0]      amask;
    logic            bad;
    logic [SB-1:0]   wstrb_d;
    logic [XLEN-1:0] wdata_d;
    logic [AW-1:0]   addr_d;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] rdata_d;

    assign size    = in_func_i[1:0];
    assign off_d   = in_addr_i[OB-1:0];
    assign bmask   = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
    assign amask   = 3'((4'd1 << size) - 4'd1);
    assign bad     = (XLEN == 32 && size == 2'd3) || (in_func_i[2] && in_wen_i) || |(in_addr_i[2:0] & amask);
    assign wstrb_d = in_wen_i ? SB'(bmask) << off_d : '0;
    assign wdata_d = in_wdata_i << {off_d, 3'b000};
    assign addr_d  = in_addr_i & ~AW'(SB - 1);

    // Load realignment uses the offset latched at accept time, not the live input.
    assign sh      = mem_rdata_i >> {off_q, 3'b000};
    assign rdata_d = wen_q ? '0 :
                     func_q[1:0] == 2'd0 ? (func_q[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
                     func_q[1:0] == 2'd1 ? (func_q[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                     func_q[1:0] == 2'd2 ? (func_q[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            func_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    func_q <= in_func_i;
                    off_q  <= off_d;
                    if (bad) begin
                        state_q <= RESP;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= REQ;
                        wen_q   <= in_wen_i;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
                    end
                end
                REQ: if (mem_ready_i) state_q <= WAIT;
                WAIT: if (mem_rvalid_i) begin
                    state_q <= RESP;
                    rdata_q <= rdata_d;
                    err_q   <= 1'b0;
                end
                RESP: if (out_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign mem_valid_o = state_q == REQ;
    assign out_valid_o = state_q == RESP;
    assign out_rdata_o = rdata_q;
    assign out_err_o   = err_q;
    assign mem_wen_o   = wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
endmodule
